regs_wb_ctrl: RTL and testbench

Write-port arbiter and scoreboard for the 32x32 register file. Shares the file's single write port between the single-cycle ex writeback and a long-latency unit (mul/div/load) that returns results through a one-entry holding buffer. Tracks destination registers of in-flight long-latency ops and stalls id on RAW/WAW hazards. Sits between ex and the register file write port; its stall/hold outputs go to the pipeline control.

---
 rtl/regs_wb_ctrl.sv | 103 ++++++++++
 tb/tb_regs_wb_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regs_wb_ctrl.sv
// Register-file write-port arbiter between ex writeback and a buffered long-latency unit,
// plus a pending-destination scoreboard that stalls id on RAW/WAW hazards.
module regs_wb_ctrl #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_wen_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        lu_issue_i,
  input  logic [4:0]  lu_issue_rd_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_rd_i,
  input  logic [31:0] lu_wdata_i,
  output logic        lu_ready_o,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_wen_i,
  output logic        stall_o,
  output logic        hold_o,
  output logic        reg_wen_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o
);

  localparam logic [3:0] AGE_MAX = 4'(STARVE_MAX);

  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic        buf_valid;
  logic [4:0]  buf_rd;
  logic [31:0] buf_data;
  logic [3:0]  age;

  logic        ex_write;
  logic        buf_force;
  logic        buf_commit;
  logic        buf_accept;

  assign ex_write   = ex_wen_i && (ex_waddr_i != 5'd0);
  assign buf_force  = buf_valid && (age >= AGE_MAX);
  assign buf_commit = buf_valid && (buf_force || !ex_write);
  // Refill is blocked during the commit cycle because buf_valid is still set.
  assign buf_accept = lu_valid_i && !buf_valid;

  // Outputs are gated by rst so nothing leaks out while reset is held.
  always_comb begin
    lu_ready_o  = 1'b0;
    hold_o      = 1'b0;
    reg_wen_o   = 1'b0;
    reg_waddr_o = 5'd0;
    reg_wdata_o = 32'd0;
    if (!rst) begin
      lu_ready_o = !buf_valid;
      hold_o     = buf_force;
      if (buf_commit) begin
        reg_wen_o   = 1'b1;
        reg_waddr_o = buf_rd;
        reg_wdata_o = buf_data;
      end else if (ex_write) begin
        reg_wen_o   = 1'b1;
        reg_waddr_o = ex_waddr_i;
        reg_wdata_o = ex_wdata_i;
      end
    end
  end

  assign stall_o = pending[id_rs1_i] | pending[id_rs2_i] | (id_wen_i & pending[id_rd_i]);

  // A new issue to the register being committed wins over the clear.
  always_comb begin
    pending_nxt = pending;
    if (buf_commit) pending_nxt[buf_rd] = 1'b0;
    if (lu_issue_i && (lu_issue_rd_i != 5'd0)) pending_nxt[lu_issue_rd_i] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= 32'd0;
      buf_valid <= 1'b0;
      buf_rd    <= 5'd0;
      buf_data  <= 32'd0;
      age       <= 4'd0;
    end else begin
      pending <= pending_nxt;
      if (buf_commit) begin
        buf_valid <= 1'b0;
        age       <= 4'd0;
      end else if (buf_accept) begin
        buf_valid <= 1'b1;
        buf_rd    <= lu_rd_i;
        buf_data  <= lu_wdata_i;
        age       <= 4'd0;
      end else if (buf_valid && (age < AGE_MAX)) begin
        age <= age + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_regs_wb_ctrl.sv
// Scoreboard bench for regs_wb_ctrl: expected register writes are queued by the
// stimulus and checked by an independent monitor on the falling edge.
module tb_regs_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_wen_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        lu_issue_i;
  logic [4:0]  lu_issue_rd_i;
  logic        lu_valid_i;
  logic [4:0]  lu_rd_i;
  logic [31:0] lu_wdata_i;
  logic        lu_ready_o;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic [4:0]  id_rd_i;
  logic        id_wen_i;
  logic        stall_o;
  logic        hold_o;
  logic        reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        hold;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regs_wb_ctrl #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .ex_wen_i(ex_wen_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .lu_issue_i(lu_issue_i), .lu_issue_rd_i(lu_issue_rd_i),
    .lu_valid_i(lu_valid_i), .lu_rd_i(lu_rd_i), .lu_wdata_i(lu_wdata_i),
    .lu_ready_o(lu_ready_o),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_wen_i(id_wen_i),
    .stall_o(stall_o), .hold_o(hold_o),
    .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Monitor: every write presented on the port must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && reg_wen_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h hold=%0b, required no write",
                 reg_waddr_o, reg_wdata_o, hold_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (reg_waddr_o !== e.addr || reg_wdata_o !== e.data || hold_o !== e.hold) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h hold=%0b, required addr=%0d data=%h hold=%0b",
                   reg_waddr_o, reg_wdata_o, hold_o, e.addr, e.data, e.hold);
        end
      end
    end
  end

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d, input logic h);
    exp_t e;
    e.addr = a; e.data = d; e.hold = h;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ex_wen_i = 1'b1; ex_waddr_i = 5'd6; ex_wdata_i = 32'h1234_5678;
    lu_issue_i = 1'b0; lu_issue_rd_i = 5'd0;
    lu_valid_i = 1'b1; lu_rd_i = 5'd2; lu_wdata_i = 32'h2222_2222;
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_rd_i = 5'd0; id_wen_i = 1'b0;

    // Reset with requests asserted: everything quiet.
    step(); step();
    sample();
    chk("rst_lu_ready", 32'(lu_ready_o), 32'd0);
    chk("rst_reg_wen", 32'(reg_wen_o), 32'd0);
    chk("rst_waddr", 32'(reg_waddr_o), 32'd0);
    chk("rst_wdata", reg_wdata_o, 32'd0);
    chk("rst_stall_hold", {30'd0, stall_o, hold_o}, 32'd0);
    step();
    ex_wen_i = 1'b0; lu_valid_i = 1'b0;
    rst = 1'b0;
    sample();
    chk("post_rst_lu_ready", 32'(lu_ready_o), 32'd1);

    // ex-only writeback, same cycle.
    step();
    ex_wen_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'hDEAD_BEEF;
    expect_write(5'd5, 32'hDEAD_BEEF, 1'b0);
    sample();
    chk("ex_wen", 32'(reg_wen_o), 32'd1);
    step();
    ex_waddr_i = 5'd0;
    sample();
    chk("ex_x0_wen", 32'(reg_wen_o), 32'd0);
    step();
    ex_wen_i = 1'b0;

    // Scoreboard: issue rd=7, then return its result with ex idle.
    lu_issue_i = 1'b1; lu_issue_rd_i = 5'd7; id_rs1_i = 5'd7;
    step();
    lu_issue_i = 1'b0;
    sample();
    chk("sb_stall_pending7", 32'(stall_o), 32'd1);
    step();
    lu_valid_i = 1'b1; lu_rd_i = 5'd7; lu_wdata_i = 32'h11;
    expect_write(5'd7, 32'h11, 1'b0);
    sample();
    chk("sb_no_write_handshake", 32'(reg_wen_o), 32'd0);
    step();
    lu_valid_i = 1'b0;
    sample();
    chk("sb_stall_commit_cycle", 32'(stall_o), 32'd1);
    chk("sb_ready_commit_cycle", 32'(lu_ready_o), 32'd0);
    step();
    sample();
    chk("sb_stall_after_commit", 32'(stall_o), 32'd0);
    chk("sb_ready_after_commit", 32'(lu_ready_o), 32'd1);

    // Arbitration: buffer holds rd=3 while ex writes every cycle.
    step();
    id_rs1_i = 5'd0;
    lu_valid_i = 1'b1; lu_rd_i = 5'd3; lu_wdata_i = 32'h33;
    step();
    lu_valid_i = 1'b0;
    ex_wen_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex_waddr_i = 5'(10 + i); ex_wdata_i = 32'hA000_0000 + 32'(i);
      expect_write(5'(10 + i), 32'hA000_0000 + 32'(i), 1'b0);
      sample();
      chk("arb_no_hold", 32'(hold_o), 32'd0);
      step();
    end
    ex_waddr_i = 5'd14; ex_wdata_i = 32'hA000_0004;
    expect_write(5'd3, 32'h33, 1'b1);
    sample();
    chk("arb_force_hold", 32'(hold_o), 32'd1);
    chk("arb_force_addr", 32'(reg_waddr_o), 32'd3);
    step();
    expect_write(5'd14, 32'hA000_0004, 1'b0);
    sample();
    chk("arb_hold_drops", 32'(hold_o), 32'd0);
    chk("arb_ready_after", 32'(lu_ready_o), 32'd1);
    step();
    ex_wen_i = 1'b0;

    // Simultaneous commit and re-issue of rd=9.
    lu_issue_i = 1'b1; lu_issue_rd_i = 5'd9;
    step();
    lu_issue_i = 1'b0;
    lu_valid_i = 1'b1; lu_rd_i = 5'd9; lu_wdata_i = 32'h99;
    step();
    lu_valid_i = 1'b0;
    lu_issue_i = 1'b1; lu_issue_rd_i = 5'd9;
    expect_write(5'd9, 32'h99, 1'b0);
    step();
    lu_issue_i = 1'b0;
    id_rs2_i = 5'd9;
    sample();
    chk("simul_pending9", 32'(stall_o), 32'd1);
    step();
    id_rs2_i = 5'd0;
    lu_issue_i = 1'b1; lu_issue_rd_i = 5'd0;
    step();
    lu_issue_i = 1'b0;
    id_wen_i = 1'b1; id_rd_i = 5'd0;
    sample();
    chk("issue_x0_no_pending", 32'(stall_o), 32'd0);
    id_rd_i = 5'd9;
    #1;
    chk("waw_stall_rd9", 32'(stall_o), 32'd1);
    step();
    id_wen_i = 1'b0; id_rd_i = 5'd0;

    // Reset mid-operation with a waiting buffer and pending[4].
    lu_issue_i = 1'b1; lu_issue_rd_i = 5'd4;
    step();
    lu_issue_i = 1'b0;
    lu_valid_i = 1'b1; lu_rd_i = 5'd4; lu_wdata_i = 32'h44;
    ex_wen_i = 1'b1; ex_waddr_i = 5'd20; ex_wdata_i = 32'hB0;
    expect_write(5'd20, 32'hB0, 1'b0);
    step();
    lu_valid_i = 1'b0;
    ex_waddr_i = 5'd21; ex_wdata_i = 32'hB1;
    expect_write(5'd21, 32'hB1, 1'b0);
    sample();
    chk("midop_ready_full", 32'(lu_ready_o), 32'd0);
    step();
    ex_wen_i = 1'b0;
    rst = 1'b1;
    id_rs1_i = 5'd4;
    sample();
    chk("midop_rst_no_write", 32'(reg_wen_o), 32'd0);
    step();
    rst = 1'b0;
    sample();
    chk("midop_after_no_write", 32'(reg_wen_o), 32'd0);
    chk("midop_stall_cleared", 32'(stall_o), 32'd0);
    chk("midop_ready", 32'(lu_ready_o), 32'd1);
    step(); step();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
